// File: rtl/ram_store_pkg.sv
// Shared RAM-store geometry and responder state encoding, common to cu and the
// store responder so both agree on result RAM size.
package ram_store_pkg;

    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        DUMP,
        DONE
    } state_t;

endpackage

// File: rtl/ram_store_resp_store_mem.sv
// Result RAM: DEPTH x DATA_W flop array, async active-low clear,
// one synchronous write port, one combinational read port.
module store_mem
    import ram_store_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_store_resp.sv
// RAM-store responder: captures cu result writes while idle and replays the
// whole result RAM in address order over a valid/ready dump port on st_out.
module ram_store_resp
    import ram_store_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_ram,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              st_out,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              busy,
    output logic              done,
    output logic              ovr_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state;
    logic              fire;
    logic              mem_we;
    logic [ADDR_W-1:0] nxt_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] start_data;

    assign fire     = dump_valid & dump_ready;
    assign mem_we   = w_ram & (state == IDLE);
    assign nxt_addr = dump_addr + ADDR_W'(1);
    // Read port prefetches the next word during a dump, entry 0 otherwise.
    assign rd_addr  = (state == DUMP) ? nxt_addr : '0;
    // A same-edge write to entry 0 must appear as the first dumped word.
    assign start_data = (w_ram && (wr_addr == '0)) ? wr_data : rd_data;

    store_mem #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mem (
        .clk  (clk),
        .rst_n(rst),
        .we   (mem_we),
        .waddr(wr_addr),
        .wdata(wr_data),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            dump_data  <= '0;
            ovr_err    <= 1'b0;
        end else begin
            if (w_ram && (state != IDLE)) begin
                ovr_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (st_out) begin
                        state      <= DUMP;
                        dump_addr  <= '0;
                        dump_data  <= start_data;
                        dump_valid <= 1'b1;
                    end
                end
                DUMP: begin
                    if (fire) begin
                        dump_addr <= nxt_addr;
                        if (dump_addr == LAST_ADDR) begin
                            dump_valid <= 1'b0;
                            state      <= DONE;
                        end else begin
                            dump_data <= rd_data;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == DUMP);
    assign done = (state == DONE);

endmodule
